// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results directly and stalls for data-memory
// loads, with flush squashing, a load timeout and a retired-write counter.
module wb_stage #(
    parameter int DW  = 16,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_rd,
    input  logic [DW-1:0] in_res,
    input  logic          in_we,
    input  logic          in_load,
    input  logic          in_byte,
    input  logic          flush,
    output logic          mem_req,
    output logic [DW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [2:0]    WB_addr,
    output logic [DW-1:0] WB_data,
    output logic          RegWe,
    output logic          stall,
    output logic          load_err,
    output logic [15:0]   retired
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, COMMIT} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t        state, state_nx;
    logic          accept;
    logic          ld_done;
    logic          ld_tmo;
    logic          waiting;
    logic [2:0]    rd_q;
    logic          we_q;
    logic          byte_q;
    logic [7:0]    cnt;
    logic [DW-1:0] ld_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        waiting  = (state == LOAD_WAIT);
        in_ready = ~waiting;
        stall    = waiting;
        mem_req  = waiting;
        RegWe    = (state == COMMIT) && we_q;
        accept   = in_valid && in_ready && !flush;
        // flush outranks a same-cycle ack; ack outranks the timeout
        ld_done  = waiting && !flush && mem_ack;
        ld_tmo   = waiting && !flush && !mem_ack && (cnt == TMO_LAST);
        ld_data  = byte_q ? {{(DW-8){mem_rdata[7]}}, mem_rdata[7:0]} : mem_rdata;
        case (state)
            IDLE, COMMIT: begin
                if (accept) state_nx = in_load ? LOAD_WAIT : COMMIT;
                else        state_nx = IDLE;
            end
            LOAD_WAIT: begin
                if (flush || ld_tmo) state_nx = IDLE;
                else if (ld_done)    state_nx = COMMIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // WB_addr/WB_data only change on entry to COMMIT, so they hold elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            cnt      <= '0;
            mem_addr <= '0;
            WB_addr  <= '0;
            WB_data  <= '0;
            load_err <= 1'b0;
            retired  <= '0;
        end else begin
            if (accept) begin
                we_q <= in_we;
                if (in_load) begin
                    rd_q     <= in_rd;
                    byte_q   <= in_byte;
                    mem_addr <= in_res;
                    cnt      <= '0;
                end else begin
                    WB_addr <= in_rd;
                    WB_data <= in_res;
                end
            end
            if (ld_done) begin
                WB_addr <= rd_q;
                WB_data <= ld_data;
            end else if (waiting && !flush) begin
                cnt <= cnt + 8'd1;
            end
            if (ld_tmo) load_err <= 1'b1;
            if (RegWe)  retired  <= retired + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a transaction-level model is checked every
// cycle, and literal expectations pin the key scenarios.
module tb_wb_stage;

    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_we, in_load, in_byte, flush, mem_ack;
    logic [2:0]    in_rd;
    logic [DW-1:0] in_res, mem_rdata;
    logic          in_ready, mem_req, RegWe, stall, load_err;
    logic [DW-1:0] mem_addr, WB_data;
    logic [2:0]    WB_addr;
    logic [15:0]   retired;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage #(.DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_res(in_res), .in_we(in_we),
        .in_load(in_load), .in_byte(in_byte), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .WB_addr(WB_addr), .WB_data(WB_data), .RegWe(RegWe),
        .stall(stall), .load_err(load_err), .retired(retired)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a load is either outstanding (with its age in wait cycles) or not;
    // a commit is a one-cycle event carrying the write it performs.
    logic        m_busy, m_ld_we, m_ld_byte, m_commit, m_cwe, m_err;
    int          m_age;
    logic [2:0]  m_ld_rd, m_wb_addr;
    logic [15:0] m_addr, m_wb_data, m_retired;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_age <= 0; m_ld_we <= 0; m_ld_byte <= 0; m_ld_rd <= 0;
            m_commit <= 0; m_cwe <= 0; m_err <= 0; m_addr <= 0;
            m_wb_addr <= 0; m_wb_data <= 0; m_retired <= 0;
        end else begin
            if (m_commit && m_cwe) m_retired <= m_retired + 16'd1;
            m_commit <= 0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 0;
                end else if (mem_ack) begin
                    m_busy    <= 0;
                    m_commit  <= 1;
                    m_cwe     <= m_ld_we;
                    m_wb_addr <= m_ld_rd;
                    m_wb_data <= m_ld_byte ? (({8'h00, mem_rdata[7:0]} ^ 16'h0080) - 16'h0080)
                                           : mem_rdata;
                end else begin
                    m_age <= m_age + 1;
                    if (m_age + 1 == TMO) begin
                        m_busy <= 0;
                        m_err  <= 1;
                    end
                end
            end else if (in_valid && !flush) begin
                if (in_load) begin
                    m_busy <= 1; m_age <= 0; m_addr <= in_res;
                    m_ld_rd <= in_rd; m_ld_we <= in_we; m_ld_byte <= in_byte;
                end else begin
                    m_commit <= 1; m_cwe <= in_we;
                    m_wb_addr <= in_rd; m_wb_data <= in_res;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", in_ready, !m_busy);
            chk("stall",    stall,    m_busy);
            chk("mem_req",  mem_req,  m_busy);
            chk("mem_addr", mem_addr, m_addr);
            chk("RegWe",    RegWe,    m_commit && m_cwe);
            chk("WB_addr",  WB_addr,  m_wb_addr);
            chk("WB_data",  WB_data,  m_wb_data);
            chk("load_err", load_err, m_err);
            chk("retired",  retired,  m_retired);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] rd, input logic [15:0] res,
                         input logic we, input logic ld, input logic bt);
        in_valid = 1; in_rd = rd; in_res = res; in_we = we; in_load = ld; in_byte = bt;
    endtask

    task automatic quiet;
        in_valid = 0; in_load = 0; in_byte = 0; flush = 0; mem_ack = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_stall"},    stall,    0);
        chk({tag, "_mem_req"},  mem_req,  0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_WB_addr"},  WB_addr,  0);
        chk({tag, "_WB_data"},  WB_data,  0);
        chk({tag, "_RegWe"},    RegWe,    0);
        chk({tag, "_load_err"}, load_err, 0);
        chk({tag, "_retired"},  retired,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1;
        quiet;
        in_rd = 0; in_res = 0; in_we = 0; mem_rdata = 0;
        #2 rst_n = 0;
        #1 chk_reset_vals("por");
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        tick;

        // ALU op commits one cycle after acceptance
        issue(3'd3, 16'h1234, 1, 0, 0);
        tick;
        chk("alu_RegWe", RegWe, 1);
        chk("alu_WB_addr", WB_addr, 3);
        chk("alu_WB_data", WB_data, 16'h1234);
        quiet;
        tick;
        chk("alu_retired", retired, 1);
        chk("alu_RegWe_off", RegWe, 0);
        chk("alu_WB_hold", WB_data, 16'h1234);

        // byte load, ack in the third wait cycle
        issue(3'd5, 16'h0040, 1, 1, 1);
        tick;
        quiet;
        for (int i = 0; i < 3; i++) begin
            chk("bl_stall", stall, 1);
            chk("bl_mem_req", mem_req, 1);
            chk("bl_mem_addr", mem_addr, 16'h0040);
            if (i == 2) begin
                mem_ack = 1; mem_rdata = 16'h00F5;
            end
            tick;
        end
        mem_ack = 0;
        chk("bl_RegWe", RegWe, 1);
        chk("bl_WB_data", WB_data, 16'hFFF5);
        chk("bl_WB_addr", WB_addr, 5);
        chk("bl_stall_off", stall, 0);
        tick;
        chk("bl_RegWe_off", RegWe, 0);
        chk("bl_retired", retired, 2);

        // word load with we=0: commit cycle without a write
        issue(3'd2, 16'h0080, 0, 1, 0);
        tick;
        quiet;
        mem_ack = 1; mem_rdata = 16'hABCD;
        tick;
        mem_ack = 0;
        chk("wl_RegWe", RegWe, 0);
        chk("wl_WB_data", WB_data, 16'hABCD);
        tick;
        chk("wl_retired", retired, 2);

        // four back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            issue(3'(i + 1), 16'h1000 + 16'(i), 1, 0, 0);
            tick;
            chk("b2b_RegWe", RegWe, 1);
            chk("b2b_WB_data", WB_data, 16'h1000 + 16'(i));
            chk("b2b_stall", stall, 0);
        end
        quiet;
        tick;
        chk("b2b_retired", retired, 6);

        // flush during COMMIT blocks the next accept but not the commit
        issue(3'd6, 16'h5555, 1, 0, 0);
        tick;
        issue(3'd7, 16'h7777, 1, 0, 0);
        flush = 1;
        chk("fc_RegWe", RegWe, 1);
        chk("fc_WB_addr", WB_addr, 6);
        tick;
        quiet;
        chk("fc_blocked", RegWe, 0);
        chk("fc_WB_hold", WB_addr, 6);

        // load accepted from COMMIT, then flushed with a simultaneous ack
        issue(3'd4, 16'h0100, 1, 0, 0);
        tick;
        issue(3'd1, 16'h0200, 1, 1, 0);
        chk("fl_prev_commit", RegWe, 1);
        tick;
        quiet;
        chk("fl_mem_req", mem_req, 1);
        chk("fl_mem_addr", mem_addr, 16'h0200);
        tick;
        flush = 1; mem_ack = 1; mem_rdata = 16'h1111;
        tick;
        quiet;
        chk("fl_mem_req_off", mem_req, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_no_write", RegWe, 0);
        chk("fl_WB_hold", WB_addr, 4);
        tick;
        chk("fl_retired", retired, 8);

        // timeout: no ack for TMO wait cycles
        issue(3'd3, 16'h0300, 1, 1, 0);
        tick;
        quiet;
        for (int i = 0; i < TMO; i++) begin
            chk("to_mem_req", mem_req, 1);
            chk("to_err_low", load_err, 0);
            tick;
        end
        chk("to_load_err", load_err, 1);
        chk("to_mem_req_off", mem_req, 0);
        chk("to_no_write", RegWe, 0);
        chk("to_in_ready", in_ready, 1);
        issue(3'd2, 16'h2222, 1, 0, 0);
        tick;
        quiet;
        chk("to_next_RegWe", RegWe, 1);
        chk("to_err_sticky", load_err, 1);
        tick;
        chk("to_err_sticky2", load_err, 1);
        chk("to_retired", retired, 9);

        // asynchronous reset in the middle of a load
        issue(3'd5, 16'h0500, 1, 1, 0);
        tick;
        quiet;
        chk("rm_mem_req", mem_req, 1);
        #2 rst_n = 0;
        #1 chk_reset_vals("rm");
        @(negedge clk);
        #1 rst_n = 1;
        issue(3'd7, 16'hBEEF, 1, 0, 0);
        tick;
        quiet;
        chk("rm_RegWe", RegWe, 1);
        chk("rm_WB_addr", WB_addr, 7);
        chk("rm_WB_data", WB_data, 16'hBEEF);
        tick;
        chk("rm_retired", retired, 1);

        repeat (2) tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameters: DW, 16, data width; TMO, 15, load-timeout limit in cycles (1..255).
REQ-002 SHALL have ports: clk  in  1  clock, all state updated on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1  upstream instruction valid.
REQ-005 SHALL have ports: in_ready  out  1  stage can accept an instruction this cycle.
REQ-006 SHALL have ports: in_rd  in  3  destination register index.
REQ-007 SHALL have ports: in_res  in  DW  ALU result; the load address when in_load=1.
REQ-008 SHALL have ports: in_we  in  1  instruction writes the register file.
REQ-009 SHALL have ports: in_load  in  1  instruction is a load.
REQ-010 SHALL have ports: in_byte  in  1  load is a byte load, sign-extended.
REQ-011 SHALL have ports: flush  in  1  interrupt/branch squash.
REQ-012 SHALL have ports: mem_req  out  1  data-memory read request.
REQ-013 SHALL have ports: mem_addr  out  DW  read address.
REQ-014 SHALL have ports: mem_rdata  in  DW  read data, valid with mem_ack.
REQ-015 SHALL have ports: mem_ack  in  1  read completion.
REQ-016 SHALL have ports: WB_addr  out  3, WB_data  out  DW, RegWe  out  1 (active-high write strobe to the register file).
REQ-017 SHALL have ports: stall  out  1  pipeline hold request; load_err  out  1  sticky timeout flag; retired  out  16  commit counter.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD_WAIT, COMMIT.
REQ-019 SHALL drive in_ready=1 in IDLE and COMMIT, and in_ready=0 in LOAD_WAIT; stall SHALL equal ~in_ready.
REQ-020 SHALL accept an instruction on a cycle with in_valid & in_ready & ~flush.
- Non-load: latch rd, in_res, in_we; go to COMMIT.
- Load: latch rd, in_we, in_byte; set mem_addr=in_res and mem_req=1 from the next cycle; clear the timeout counter; go to LOAD_WAIT.
REQ-021 SHALL, in LOAD_WAIT, hold mem_req=1 and mem_addr stable until mem_ack.
- On mem_ack: data=mem_rdata, or {8{mem_rdata[7]}, mem_rdata[7:0]} if byte; deassert mem_req next cycle; go to COMMIT.
REQ-022 SHALL, in COMMIT, drive RegWe=latched we for exactly that cycle, with WB_addr/WB_data equal to the latched values.
REQ-023 SHALL fix non-load latency at 1 cycle: accept at edge N -> RegWe high in cycle N+1.
REQ-024 SHALL fix load latency at 1 cycle after the ack edge: ack sampled at edge M -> RegWe high in cycle M+1.
REQ-025 SHALL, when COMMIT receives a new valid, accept it in the same cycle, allowing back-to-back commits at one per cycle; otherwise COMMIT SHALL return to IDLE.
REQ-026 SHALL drive RegWe=0 and hold WB_addr/WB_data at their last values outside COMMIT.
REQ-027 SHALL NOT let flush cancel a COMMIT in progress; flush SHALL only block acceptance of a new instruction that cycle.
REQ-028 SHALL, on flush in LOAD_WAIT, return to IDLE, drop mem_req next cycle, and perform no write; a mem_ack in that same cycle SHALL be ignored.
REQ-029 SHALL count LOAD_WAIT cycles without mem_ack; on reaching TMO it SHALL set load_err=1, drop mem_req, go to IDLE, and perform no write.
REQ-030 SHALL keep load_err sticky until reset.
REQ-031 SHALL increment retired by 1 on every cycle with RegWe=1, wrapping 16'hFFFF -> 0; commits with we=0 SHALL NOT count.
REQ-032 SHALL assert RegWe for rd=0 if we=1; discarding writes to r0 is the register file's job.

Reset
REQ-033 SHALL, on rst_n=0 and at any time including mid-load, immediately set state=IDLE, mem_req=0, mem_addr=0, WB_addr=0, WB_data=0, RegWe=0, load_err=0, retired=0, and the timeout counter to 0.
REQ-034 SHALL drive in_ready=1 and stall=0 while in reset.

Verification
REQ-035 ALU op: valid, rd=3, res=16'h1234, we=1 at edge N -> RegWe=1, WB_addr=3, WB_data=16'h1234 in cycle N+1, retired=1.
REQ-036 Byte load: addr 16'h0040, byte=1, ack after 3 cycles with rdata=16'h00F5 -> stall high for 3 cycles, then WB_data=16'hFFF5 for one cycle.
REQ-037 Back-to-back: 4 consecutive ALU ops -> 4 consecutive RegWe cycles, no stall, retired=4.
REQ-038 Flush in LOAD_WAIT with simultaneous mem_ack -> no RegWe, IDLE next cycle, mem_req=0.
REQ-039 Timeout with TMO=15 and no ack -> load_err=1 after 15 wait cycles, no write, load_err held until rst_n pulse.
REQ-040 Reset asserted mid-load -> all outputs at reset values asynchronously; first instruction after release commits normally.
